// File: rtl/w_input_conditioner.sv
// Debounces a raw switch level into a clean, clk-synchronous w plus edge strobes and debug state.
// Optional macro W_INPUT_SYNC_EN adds a two-flop synchronizer in front of the debounce FSM.
module w_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       w,
  output logic       w_rise,
  output logic       w_fall,
  output logic       stable,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s;

`ifdef W_INPUT_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], raw_in};
    end
  end

  assign s = sync_reg[1];
`else
  // Input is already synchronous to clk.
  assign s = raw_in;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             w_reg, w_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             stable_reg, stable_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= LOW;
      cnt_reg    <= '0;
      w_reg      <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      stable_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      w_reg      <= w_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      stable_reg <= stable_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    w_next     = w_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      LOW: begin
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        // A bounce drops back to the settled level and discards the count.
        if (!s) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          w_next     = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          w_next     = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
    stable_next = (state_next == LOW) || (state_next == HIGH);
  end

  assign w      = w_reg;
  assign w_rise = rise_reg;
  assign w_fall = fall_reg;
  assign stable = stable_reg;
  assign State  = state_reg;

endmodule

// File: tb/tb_w_input_conditioner.sv
// Scoreboard bench for w_input_conditioner: a run-length debounce model predicts every cycle's outputs.
module tb_w_input_conditioner;

  localparam int D = 4;
`ifdef W_INPUT_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       raw_in = 1'b0;
  logic       w, w_rise, w_fall, stable;
  logic [1:0] State;

  w_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .w(w), .w_rise(w_rise), .w_fall(w_fall), .stable(stable), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic       rise;
    logic       fall;
    logic       stable;
    logic [1:0] state;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   active   = 1'b0;

  // Reference model: raw delayed through a sample history, then w flips once
  // D consecutive samples disagree with it.
  bit m_w;
  int m_run;
  bit hist[$];

  function automatic obs_t model_obs(input bit rise, input bit fall);
    obs_t o;
    o.w      = m_w;
    o.rise   = rise;
    o.fall   = fall;
    o.stable = (m_run == 0);
    o.state  = (m_run == 0) ? {m_w, m_w} : {m_w, ~m_w};
    return o;
  endfunction

  task automatic model_reset(output obs_t o);
    m_w   = 1'b0;
    m_run = 0;
    hist  = {};
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
    o = model_obs(1'b0, 1'b0);
  endtask

  task automatic model_step(input bit raw, output obs_t o);
    bit s;
    bit rise;
    bit fall;
    hist.push_back(raw);
    s    = hist.pop_front();
    rise = 1'b0;
    fall = 1'b0;
    if (s != m_w) begin
      m_run++;
      if (m_run == D) begin
        m_w   = s;
        rise  = s;
        fall  = !s;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    o = model_obs(rise, fall);
  endtask

  // One stimulus cycle: drive at negedge, push the expectation for the next posedge.
  task automatic cycle(input bit r, input bit rst_n);
    obs_t o;
    @(negedge clk);
    raw_in = r;
    reset  = rst_n;
    if (!rst_n) model_reset(o);
    else        model_step(r, o);
    exp_q.push_back(o);
    active = 1'b1;
  endtask

  task automatic hold(input bit r, input int n);
    for (int i = 0; i < n; i++) cycle(r, 1'b1);
  endtask

  // Monitor: compares DUT outputs against the queued expectation after every edge.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      got = {w, w_rise, w_fall, stable, State};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got w=%b rise=%b fall=%b stable=%b State=%b, expected w=%b rise=%b fall=%b stable=%b State=%b",
                   $time, got.w, got.rise, got.fall, got.stable, got.state,
                   e.w, e.rise, e.fall, e.stable, e.state);
        end else begin
          $display("t=%0t raw=%b reset=%b w=%b rise=%b fall=%b stable=%b State=%b ok",
                   $time, raw_in, reset, got.w, got.rise, got.fall, got.stable, got.state);
        end
      end else if (active) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard t=%0t: no expectation queued, got State=%b w=%b", $time, State, w);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t o;
    obs_t got;
    int   guard;
    bit   lvl;

    // Reset held with raw high, then release: w rises after the debounce latency.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    hold(1'b1, 10);
    // Release, then a 0,1,0 bounce inside WAIT_LOW before a clean fall.
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 10);
    // Short glitch from LOW.
    hold(1'b1, 3);
    hold(1'b0, 8);
    // Clean press again.
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Async reset mid-debounce while waiting to go high with two samples counted.
    guard = 0;
    do begin
      cycle(1'b1, 1'b1);
      guard++;
    end while (!(m_run == 2 && !m_w) && guard < 20);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    got = {w, w_rise, w_fall, stable, State};
    model_reset(o);
    n_checks++;
    if (got !== o) begin
      n_fail++;
      $display("FAIL async_reset: got w=%b rise=%b fall=%b stable=%b State=%b, expected all clear, stable=1, State=00 (guard=%0d)",
               got.w, got.rise, got.fall, got.stable, got.state, guard);
    end
    exp_q.push_back(o);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    hold(1'b0, 4);

    // Toggle every cycle: w must never change.
    for (int i = 0; i < 24; i++) cycle(i[0], 1'b1);
    hold(1'b1, 10);
    for (int i = 0; i < 24; i++) cycle(i[0], 1'b1);
    hold(1'b0, 10);

    // Randomized bouncy segments.
    for (int seg = 0; seg < 150; seg++) begin
      lvl = $urandom_range(0, 1);
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) begin
        if ($urandom_range(0, 9) == 0) cycle(!lvl, 1'b1);
        else                           cycle(lvl, 1'b1);
      end
    end
    hold(1'b0, 8);

    active = 1'b0;
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
